// File: rtl/gol_vga_renderer.sv
// gol_vga_renderer: renders the 16x16 Game of Life board as a 640x480@60 Hz VGA image.
// The board is latched once per frame at the start of vertical blanking, so every displayed
// frame shows exactly one generation. Pixel timing is derived from the system clock through
// a divide-by-CLK_DIV enable strobe.
// Optional build macro GOL_GRID_LINES_EN: draws a 12'h444 line on the first pixel row and
// column of every cell.
module gol_vga_renderer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CELL_PX   = 24,
  parameter int unsigned X_OFF     = 128,
  parameter int unsigned Y_OFF     = 48,
  parameter logic [11:0] ALIVE_RGB = 12'hFFF,
  parameter logic [11:0] DEAD_RGB  = 12'h000,
  parameter logic [11:0] BG_RGB    = 12'h222
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] board_i,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         hsync,
  output logic         vsync,
  output logic         frame_o
);

  // 640x480@60 timing, counted in pixel ticks / lines.
  localparam logic [9:0] HVisible   = 10'd640;
  localparam logic [9:0] HSyncStart = 10'd656;
  localparam logic [9:0] HSyncEnd   = 10'd751;
  localparam logic [9:0] HLast      = 10'd799;
  localparam logic [9:0] VVisible   = 10'd480;
  localparam logic [9:0] VSyncStart = 10'd490;
  localparam logic [9:0] VSyncEnd   = 10'd491;
  localparam logic [9:0] VLast      = 10'd524;

  localparam int unsigned BoardPx = 16 * CELL_PX;
  localparam logic [9:0]  XLo     = 10'(X_OFF);
  localparam logic [9:0]  XHi     = 10'(X_OFF + BoardPx);
  localparam logic [9:0]  YLo     = 10'(Y_OFF);
  localparam logic [9:0]  YHi     = 10'(Y_OFF + BoardPx);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SubW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [SubW-1:0] SubLast = SubW'(CELL_PX - 1);

`ifdef GOL_GRID_LINES_EN
  localparam logic [11:0] GridRgb = 12'h444;
`endif

  logic [DivW-1:0] divider_q, divider_d;
  logic            pix_en;
  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  // In-cell sub-pixel and cell index, tracked alongside h_cnt/v_cnt; only meaningful
  // while the counters are inside the board area.
  logic [SubW-1:0] x_sub_q, x_sub_d;
  logic [SubW-1:0] y_sub_q, y_sub_d;
  logic [3:0]      x_cell_q, x_cell_d;
  logic [3:0]      y_cell_q, y_cell_d;

  logic [255:0]    board_q;
  logic [11:0]     rgb_q;
  logic            hsync_q;
  logic            vsync_q;
  logic            frame_q;

  logic            in_visible;
  logic            in_board;
  logic [7:0]      cell_idx;
  logic [11:0]     pix_rgb;
  logic            latch_hit;

  // Pixel strobe divider.
  always_comb begin
    pix_en    = (divider_q == DivLast);
    divider_d = pix_en ? '0 : divider_q + 1'b1;
  end

  // Next-state for the raster counters and the incremental cell coordinates.
  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    x_sub_d  = x_sub_q;
    x_cell_d = x_cell_q;
    y_sub_d  = y_sub_q;
    y_cell_d = y_cell_q;
    if (pix_en) begin
      h_cnt_d = (h_cnt_q == HLast) ? 10'd0 : h_cnt_q + 10'd1;
      if (h_cnt_d == XLo) begin
        x_sub_d  = '0;
        x_cell_d = 4'd0;
      end else if (x_sub_q == SubLast) begin
        x_sub_d  = '0;
        x_cell_d = x_cell_q + 4'd1;
      end else begin
        x_sub_d = x_sub_q + 1'b1;
      end
      if (h_cnt_q == HLast) begin
        v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
        if (v_cnt_d == YLo) begin
          y_sub_d  = '0;
          y_cell_d = 4'd0;
        end else if (y_sub_q == SubLast) begin
          y_sub_d  = '0;
          y_cell_d = y_cell_q + 4'd1;
        end else begin
          y_sub_d = y_sub_q + 1'b1;
        end
      end
    end
  end

  // Colour of the pixel addressed by the current counters.
  always_comb begin
    in_visible = (h_cnt_q < HVisible) && (v_cnt_q < VVisible);
    in_board   = (h_cnt_q >= XLo) && (h_cnt_q < XHi) && (v_cnt_q >= YLo) && (v_cnt_q < YHi);
    cell_idx   = {y_cell_q, x_cell_q};
    pix_rgb    = 12'h000;
    if (in_visible) begin
      if (in_board) begin
        pix_rgb = board_q[cell_idx] ? ALIVE_RGB : DEAD_RGB;
`ifdef GOL_GRID_LINES_EN
        if ((x_sub_q == '0) || (y_sub_q == '0)) begin
          pix_rgb = GridRgb;
        end
`endif
      end else begin
        pix_rgb = BG_RGB;
      end
    end
    latch_hit = pix_en && (h_cnt_q == 10'd0) && (v_cnt_q == VVisible);
  end

  // Divider, raster counters and cell coordinates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider_q <= '0;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      x_sub_q   <= '0;
      x_cell_q  <= 4'd0;
      y_sub_q   <= '0;
      y_cell_q  <= 4'd0;
    end else begin
      divider_q <= divider_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      x_sub_q   <= x_sub_d;
      x_cell_q  <= x_cell_d;
      y_sub_q   <= y_sub_d;
      y_cell_q  <= y_cell_d;
    end
  end

  // Board snapshot taken at the start of vertical blanking, with its one-clk marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= latch_hit;
      if (latch_hit) begin
        board_q <= board_i;
      end
    end
  end

  // Colour and syncs registered together so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en) begin
      rgb_q   <= pix_rgb;
      hsync_q <= !((h_cnt_q >= HSyncStart) && (h_cnt_q <= HSyncEnd));
      vsync_q <= !((v_cnt_q >= VSyncStart) && (v_cnt_q <= VSyncEnd));
    end
  end

  assign vga_r   = rgb_q[11:8];
  assign vga_g   = rgb_q[7:4];
  assign vga_b   = rgb_q[3:0];
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_gol_vga_renderer.sv
// Directed bench for gol_vga_renderer (default build, no grid lines).
// Time is tracked as clk edges since reset release; the pixel with raster index p is
// registered at edge 4*(p+1), and a frame spans 420000 pixel ticks.
module tb_gol_vga_renderer;

  localparam int FramePix = 420000;

  logic         clk;
  logic         reset;
  logic [255:0] board_i;
  logic [3:0]   vga_r, vga_g, vga_b;
  logic         hsync, vsync, frame_o;
  logic [11:0]  rgb;

  int n_checks;
  int n_errors;
  int cyc;

  logic [255:0] board_a;
  logic [255:0] board_b;

  gol_vga_renderer dut (
    .clk     (clk),
    .reset   (reset),
    .board_i (board_i),
    .vga_r   (vga_r),
    .vga_g   (vga_g),
    .vga_b   (vga_b),
    .hsync   (hsync),
    .vsync   (vsync),
    .frame_o (frame_o)
  );

  assign rgb = {vga_r, vga_g, vga_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after edge t.
  task automatic wait_cyc(input int t);
    if (cyc >= t) check("schedule", cyc, t - 1);
    forever begin
      if (cyc >= t) break;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pix_edge(input int f, input int h, input int v);
    return 4 * (f * FramePix + v * 800 + h + 1);
  endfunction

  task automatic check_pix(input string tag, input int f, input int h, input int v,
                           input logic [11:0] exp);
    wait_cyc(pix_edge(f, h, v));
    check(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic check_at(input string tag, input int t, input logic got_sel,
                          input logic exp);
    // got_sel: 0 = hsync, 1 = vsync
    wait_cyc(t);
    check(tag, got_sel ? 32'(vsync) : 32'(hsync), 32'(exp));
  endtask

  task automatic check_frame(input string tag, input int t, input logic exp);
    wait_cyc(t);
    check(tag, 32'(frame_o), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    board_a = '0;
    board_a[0] = 1'b1;    // row 0, col 0
    board_a[240] = 1'b1;  // row 15, col 0
    board_b = '0;
    board_b[255] = 1'b1;  // row 15, col 15
    board_i = board_a;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {16'h0, rgb, hsync, vsync, frame_o, 1'b0}, {16'h0, 12'h000, 4'b1100});
    reset = 1'b0;

    // Frame 0: board snapshot still cleared.
    check_pix("f0_bg_0_0", 0, 0, 0, 12'h222);
    check_at("hsync_pre_fall", 2627, 1'b0, 1'b1);
    check_at("hsync_fall", 2628, 1'b0, 1'b0);
    check_at("hsync_last_low", 3011, 1'b0, 1'b0);
    check_at("hsync_rise", 3012, 1'b0, 1'b1);
    check_at("hsync_fall2", 5828, 1'b0, 1'b0);
    check_pix("f0_hblank", 0, 700, 10, 12'h000);
    check_pix("f0_board_dead", 0, 128, 48, 12'h000);
    check_frame("frame_pre", 1536003, 1'b0);
    check_frame("frame_pulse", 1536004, 1'b1);
    check_frame("frame_post", 1536005, 1'b0);
    check_at("vsync_pre_fall", 1568003, 1'b1, 1'b1);
    check_at("vsync_fall", 1568004, 1'b1, 1'b0);
    check_at("vsync_last_low", 1574403, 1'b1, 1'b0);
    check_at("vsync_rise", 1574404, 1'b1, 1'b1);

    // Frame 1: board_a displayed; board_i changes mid-frame without visible effect.
    check_pix("f1_bg_0_0", 1, 0, 0, 12'h222);
    check_pix("f1_left_of_board", 1, 127, 48, 12'h222);
    check_pix("f1_cell0_tl", 1, 128, 48, 12'hFFF);
    check_pix("f1_cell1_tl", 1, 152, 48, 12'h000);
    check_pix("f1_cell0_br", 1, 151, 71, 12'hFFF);
    wait_cyc(pix_edge(1, 0, 200));
    board_i = board_b;
    check_pix("f1_r15c0_kept", 1, 128, 408, 12'hFFF);
    check_pix("f1_r15c15_kept", 1, 488, 408, 12'h000);
    check_frame("frame2_pre", 1536003 + 4 * FramePix, 1'b0);
    check_frame("frame2_pulse", 1536004 + 4 * FramePix, 1'b1);
    check_at("vsync_fall2", 1568004 + 4 * FramePix, 1'b1, 1'b0);

    // Frame 2: board_b displayed.
    check_pix("f2_cell0_dead", 2, 128, 48, 12'h000);
    check_pix("f2_r15c0_dead", 2, 128, 408, 12'h000);
    check_pix("f2_r15c15_tl", 2, 488, 408, 12'hFFF);
    check_pix("f2_hblank", 2, 700, 420, 12'h000);
    check_pix("f2_r15c15_br", 2, 511, 431, 12'hFFF);
    check_pix("f2_past_board", 2, 512, 431, 12'h222);
    check_pix("f2_bg_mid", 2, 600, 431, 12'h222);

    // Asynchronous reset mid-line.
    #1 reset = 1'b1;
    #1 check("midreset_outputs", {16'h0, rgb, hsync, vsync, frame_o, 1'b0},
             {16'h0, 12'h000, 4'b1100});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_pix("rst_bg_0_0", 0, 0, 0, 12'h222);
    check_at("rst_hsync_pre_fall", 2627, 1'b0, 1'b1);
    check_at("rst_hsync_fall", 2628, 1'b0, 1'b0);
    check_at("rst_hsync_rise", 3012, 1'b0, 1'b1);
    check_pix("rst_board_dead", 0, 128, 48, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
